// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone classic initiator.
package wb_initiator_pkg;

  localparam int unsigned DefaultAddrW = 32;
  localparam int unsigned DefaultDataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } wb_state_e;

  function automatic int unsigned sel_width(int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/wb_initiator.sv
// Wishbone B4 classic single-transfer initiator driven by a cmd/resp valid-ready pair.
// Define WB_INITIATOR_TIMEOUT_EN to build the ack timeout counter and abort path.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefaultAddrW,
  parameter int unsigned DATA_W         = DefaultDataW,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned SEL_W         = sel_width(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_val,
  output logic              cmd_rdy,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [DATA_W-1:0] resp_dat,
  output logic              resp_err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  input  logic              wbm_ack_i,
  input  logic [DATA_W-1:0] wbm_dat_i
);

  wb_state_e         state_q, state_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              resp_val_q, resp_val_d;
  logic [DATA_W-1:0] resp_dat_q, resp_dat_d;

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam int unsigned       CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0]   CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            resp_err_q, resp_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    resp_val_d = resp_val_q;
    resp_dat_d = resp_dat_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
    cnt_d      = cnt_q;
    resp_err_d = resp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_val && cmd_rdy_q) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cyc_d   = 1'b1;
          state_d = StBus;
`ifdef WB_INITIATOR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StBus: begin
        // Ack takes priority over a coincident timeout.
        if (wbm_ack_i) begin
          cyc_d      = 1'b0;
          resp_dat_d = we_q ? '0 : wbm_dat_i;
          resp_val_d = 1'b1;
          state_d    = StResp;
`ifdef WB_INITIATOR_TIMEOUT_EN
          resp_err_d = 1'b0;
        end else if (cnt_q == CntLast) begin
          cyc_d      = 1'b0;
          resp_dat_d = '0;
          resp_err_d = 1'b1;
          resp_val_d = 1'b1;
          state_d    = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        if (resp_rdy) begin
          resp_val_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    cmd_rdy_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cmd_rdy_q  <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      resp_val_q <= 1'b0;
      resp_dat_q <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
      cnt_q      <= '0;
      resp_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_rdy_q  <= cmd_rdy_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      resp_val_q <= resp_val_d;
      resp_dat_q <= resp_dat_d;
`ifdef WB_INITIATOR_TIMEOUT_EN
      cnt_q      <= cnt_d;
      resp_err_q <= resp_err_d;
`endif
    end
  end

  assign cmd_rdy   = cmd_rdy_q;
  assign resp_val  = resp_val_q;
  assign resp_dat  = resp_dat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
  assign resp_err  = resp_err_q;
`else
  assign resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_initiator.sv
// Directed self-checking bench for wb_initiator (timeout scenarios follow WB_INITIATOR_TIMEOUT_EN).
module tb_wb_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_val, cmd_rdy, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        resp_val, resp_rdy, resp_err;
  logic [31:0] resp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_initiator #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_val  (cmd_val),
    .cmd_rdy  (cmd_rdy),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_dat (resp_dat),
    .resp_err (resp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL rst_cmd_rdy: got %b want 0", cmd_rdy); end
    n_cmp++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, resp_val, resp_err} !== 5'b0) begin
      n_err++; $display("FAIL rst_ctrl: got %b want 00000",
                        {wbm_cyc_o, wbm_stb_o, wbm_we_o, resp_val, resp_err}); end
    n_cmp++; if ({wbm_adr_o, wbm_dat_o, wbm_sel_o, resp_dat} !== 100'b0) begin
      n_err++; $display("FAIL rst_data: got %h want 0", {wbm_adr_o, wbm_dat_o, wbm_sel_o, resp_dat}); end
    reset = 1'b0;
    tick();
    n_cmp++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rst_release_cmd_rdy: got %b want 1", cmd_rdy); end
  endtask

  task automatic test_write();
    cmd_val = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004; cmd_dat = 32'hDEAD_BEEF;
    cmd_sel = 4'hF; resp_rdy = 1'b1; wbm_dat_i = 32'hFFFF_FFFF;
    tick();
    cmd_val = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0; cmd_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b111) begin
        n_err++; $display("FAIL wr_ctrl[%0d]: got %b want 111", i, {wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
      n_cmp++; if ({wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {32'h3000_0004, 32'hDEAD_BEEF, 4'hF}) begin
        n_err++; $display("FAIL wr_bus[%0d]: got %h %h %h want 30000004 deadbeef f",
                          i, wbm_adr_o, wbm_dat_o, wbm_sel_o); end
      n_cmp++; if (resp_val !== 1'b0) begin n_err++; $display("FAIL wr_early_resp[%0d]: got %b want 0", i, resp_val); end
      wbm_ack_i = (i == 2);
      tick();
    end
    wbm_ack_i = 1'b0;
    n_cmp++; if ({wbm_cyc_o, wbm_stb_o} !== 2'b00) begin
      n_err++; $display("FAIL wr_cyc_drop: got %b want 00", {wbm_cyc_o, wbm_stb_o}); end
    n_cmp++; if ({resp_val, resp_err, resp_dat} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL wr_resp: got val=%b err=%b dat=%h want 1 0 00000000", resp_val, resp_err, resp_dat); end
    tick();
    n_cmp++; if ({cmd_rdy, resp_val} !== 2'b10) begin
      n_err++; $display("FAIL wr_back_idle: got rdy=%b val=%b want 1 0", cmd_rdy, resp_val); end
    n_cmp++; if ({wbm_we_o, wbm_adr_o} !== {1'b1, 32'h3000_0004}) begin
      n_err++; $display("FAIL wr_idle_hold: got we=%b adr=%h want 1 30000004", wbm_we_o, wbm_adr_o); end
  endtask

  task automatic test_back_to_back();
    resp_rdy = 1'b1;
    cmd_val = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_dat = 32'hAAAA_AAAA;
    for (int t = 0; t < 3; t++) begin
      cmd_adr = 32'h3000_0010 + 32'(4 * t);
      n_cmp++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy[%0d]: got %b want 1", t, cmd_rdy); end
      tick();
      n_cmp++; if ({wbm_cyc_o, wbm_we_o, wbm_adr_o} !== {1'b1, 1'b0, 32'h3000_0010 + 32'(4 * t)}) begin
        n_err++; $display("FAIL b2b_bus[%0d]: got cyc=%b we=%b adr=%h want 1 0 %h",
                          t, wbm_cyc_o, wbm_we_o, wbm_adr_o, 32'h3000_0010 + 32'(4 * t)); end
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678 + 32'(t);
      tick();
      wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
      n_cmp++; if ({resp_val, resp_err, resp_dat} !== {1'b1, 1'b0, 32'h1234_5678 + 32'(t)}) begin
        n_err++; $display("FAIL b2b_resp[%0d]: got val=%b err=%b dat=%h want 1 0 %h",
                          t, resp_val, resp_err, resp_dat, 32'h1234_5678 + 32'(t)); end
      n_cmp++; if ({wbm_cyc_o, cmd_rdy} !== 2'b00) begin
        n_err++; $display("FAIL b2b_resp_state[%0d]: got cyc=%b rdy=%b want 0 0", t, wbm_cyc_o, cmd_rdy); end
      tick();
    end
    cmd_val = 1'b0;
    n_cmp++; if ({cmd_rdy, resp_val, wbm_cyc_o} !== 3'b100) begin
      n_err++; $display("FAIL b2b_end: got rdy=%b val=%b cyc=%b want 1 0 0", cmd_rdy, resp_val, wbm_cyc_o); end
  endtask

  task automatic test_backpressure();
    cmd_val = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'h3; resp_rdy = 1'b0;
    tick();
    cmd_adr = 32'h3000_0040;
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
    tick();
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({resp_val, resp_dat} !== {1'b1, 32'hCAFE_F00D}) begin
        n_err++; $display("FAIL bp_hold[%0d]: got val=%b dat=%h want 1 cafef00d", i, resp_val, resp_dat); end
      n_cmp++; if ({cmd_rdy, wbm_cyc_o} !== 2'b00) begin
        n_err++; $display("FAIL bp_blocked[%0d]: got rdy=%b cyc=%b want 0 0", i, cmd_rdy, wbm_cyc_o); end
      tick();
    end
    resp_rdy = 1'b1;
    tick();
    n_cmp++; if ({cmd_rdy, resp_val, wbm_cyc_o} !== 3'b100) begin
      n_err++; $display("FAIL bp_release: got rdy=%b val=%b cyc=%b want 1 0 0", cmd_rdy, resp_val, wbm_cyc_o); end
    tick();
    cmd_val = 1'b0;
    n_cmp++; if ({wbm_cyc_o, wbm_adr_o} !== {1'b1, 32'h3000_0040}) begin
      n_err++; $display("FAIL bp_next_accept: got cyc=%b adr=%h want 1 30000040", wbm_cyc_o, wbm_adr_o); end
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_0042;
    tick();
    wbm_ack_i = 1'b0;
    tick();
  endtask

`ifdef WB_INITIATOR_TIMEOUT_EN
  task automatic test_timeout();
    cmd_val = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0080; resp_rdy = 1'b1;
    wbm_dat_i = 32'h7777_7777;
    tick();
    cmd_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if ({wbm_cyc_o, resp_val} !== 2'b10) begin
        n_err++; $display("FAIL to_wait[%0d]: got cyc=%b val=%b want 1 0", i, wbm_cyc_o, resp_val); end
      tick();
    end
    n_cmp++; if ({wbm_cyc_o, resp_val, resp_err, resp_dat} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      n_err++; $display("FAIL to_abort: got cyc=%b val=%b err=%b dat=%h want 0 1 1 00000000",
                        wbm_cyc_o, resp_val, resp_err, resp_dat); end
    tick();
    cmd_val = 1'b1;
    tick();
    cmd_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (wbm_cyc_o !== 1'b1) begin n_err++; $display("FAIL to_edge_wait[%0d]: got %b want 1", i, wbm_cyc_o); end
      if (i == 7) begin wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_55AA; end
      tick();
    end
    wbm_ack_i = 1'b0;
    n_cmp++; if ({wbm_cyc_o, resp_val, resp_err, resp_dat} !== {1'b0, 1'b1, 1'b0, 32'h0000_55AA}) begin
      n_err++; $display("FAIL to_ack_wins: got cyc=%b val=%b err=%b dat=%h want 0 1 0 000055aa",
                        wbm_cyc_o, resp_val, resp_err, resp_dat); end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int cyc_low = 0;
    int err_seen = 0;
    cmd_val = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0080; resp_rdy = 1'b1;
    wbm_dat_i = 32'h0;
    tick();
    cmd_val = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (wbm_cyc_o !== 1'b1) cyc_low++;
      if (resp_err !== 1'b0 || resp_val !== 1'b0) err_seen++;
      tick();
    end
    n_cmp++; if (cyc_low !== 0) begin n_err++; $display("FAIL nto_cyc_low: got %0d cycles want 0", cyc_low); end
    n_cmp++; if (err_seen !== 0) begin n_err++; $display("FAIL nto_resp_seen: got %0d cycles want 0", err_seen); end
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_CAFE;
    tick();
    wbm_ack_i = 1'b0;
    n_cmp++; if ({wbm_cyc_o, resp_val, resp_err, resp_dat} !== {1'b0, 1'b1, 1'b0, 32'h0BAD_CAFE}) begin
      n_err++; $display("FAIL nto_late_ack: got cyc=%b val=%b err=%b dat=%h want 0 1 0 0badcafe",
                        wbm_cyc_o, resp_val, resp_err, resp_dat); end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    int val_seen = 0;
    cmd_val = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_00C0; cmd_dat = 32'h1111_2222; resp_rdy = 1'b1;
    tick();
    cmd_val = 1'b0;
    tick();
    tick();
    n_cmp++; if (wbm_cyc_o !== 1'b1) begin n_err++; $display("FAIL rm_in_bus: got %b want 1", wbm_cyc_o); end
    reset = 1'b1; wbm_ack_i = 1'b1;
    tick();
    reset = 1'b0; wbm_ack_i = 1'b0;
    n_cmp++; if ({wbm_cyc_o, wbm_stb_o, resp_val, cmd_rdy} !== 4'b0000) begin
      n_err++; $display("FAIL rm_drop: got cyc=%b stb=%b val=%b rdy=%b want 0 0 0 0",
                        wbm_cyc_o, wbm_stb_o, resp_val, cmd_rdy); end
    tick();
    n_cmp++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rm_cmd_rdy: got %b want 1", cmd_rdy); end
    for (int i = 0; i < 6; i++) begin
      if (resp_val !== 1'b0 || wbm_cyc_o !== 1'b0) val_seen++;
      tick();
    end
    n_cmp++; if (val_seen !== 0) begin n_err++; $display("FAIL rm_no_resp: got %0d cycles want 0", val_seen); end
  endtask

  initial begin
    reset = 1'b1; cmd_val = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    resp_rdy = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    test_reset();
    test_write();
    test_back_to_back();
    test_backpressure();
`ifdef WB_INITIATOR_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Wishbone classic (B4, non-pipelined) bus master: the initiator counterpart of the coprocessor's Wishbone slave port. It turns single-word commands on a valid/ready interface into one Wishbone read or write cycle and returns a response on a second valid/ready interface. Used as the bench-side and SoC-side driver of the vector coprocessor's register/memory window, and as the seed of a future DMA path.

## Interface
Parameters:
- `ADDR_W`, default 32: Wishbone address width.
- `DATA_W`, default 32: Wishbone data width; `SEL_W = DATA_W/8`.
- `TIMEOUT_CYCLES`, default 255: cycles in BUS without ack before abort. Must be ≥1.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `cmd_val` / `cmd_rdy`, in / out, 1 / 1: command handshake.
- `cmd_we`, in, 1: 1 = write, 0 = read.
- `cmd_adr`, in, `ADDR_W`: target address.
- `cmd_dat`, in, `DATA_W`: write data (ignored for reads).
- `cmd_sel`, in, `SEL_W`: byte enables.
- `resp_val` / `resp_rdy`, out / in, 1 / 1: response handshake.
- `resp_dat`, out, `DATA_W`: read data; 0 for writes and errors.
- `resp_err`, out, 1: transaction aborted by timeout.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`, out, 1 each: Wishbone control.
- `wbm_adr_o`, `wbm_dat_o`, `wbm_sel_o`, out, `ADDR_W` / `DATA_W` / `SEL_W`: Wishbone address, data and select.
- `wbm_ack_i`, in, 1: slave acknowledge.
- `wbm_dat_i`, in, `DATA_W`: slave read data.

## Operation
- Three-state FSM: IDLE, BUS, RESP. Reset → IDLE.
- IDLE: `cmd_rdy=1`. On `cmd_val&&cmd_rdy`, register `we/adr/dat/sel` onto the `wbm_*` outputs, set `cyc=stb=1`, clear the timeout counter, go to BUS.
- BUS: `cyc`, `stb`, `we`, `adr`, `dat` and `sel` are held stable. On `wbm_ack_i`:
  - drop `cyc/stb`;
  - capture `resp_dat` (`wbm_dat_i` if read, else 0);
  - set `resp_err=0`, `resp_val=1`;
  - go to RESP.
- BUS without ack: the counter increments. When the counter equals `TIMEOUT_CYCLES-1` and ack is low:
  - drop `cyc/stb`;
  - set `resp_err=1`, `resp_dat=0`, `resp_val=1`;
  - go to RESP.
- Ack and timeout in the same cycle: ack wins, normal response.
- RESP: `resp_val` and the response fields are held until `resp_rdy`. Then `resp_val=0` and go to IDLE. `cmd_rdy=0` outside IDLE.
- `wbm_adr/dat/sel/we` keep their last values when idle. Only `cyc/stb` qualify the bus.
- `wbm_ack_i` outside BUS is ignored.

## Timing
- All outputs are registered. Reset values: `cmd_rdy=0` during reset and 1 in the first cycle after it; every other output is 0.
- Command accepted at edge N → `cyc/stb` high in cycle N+1.
- Ack sampled at edge N+k (k≥1) → `resp_val` high in cycle N+k+1, `cyc/stb` low in the same cycle.
- Zero-wait-state slave with `resp_rdy` held high: one transaction per 3 cycles.
- Reset asserted mid-transaction: at the next edge `cyc/stb` drop, any pending response is discarded, FSM → IDLE. No response is ever emitted for that command.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates, never wraps.

## Configuration
- `WB_INITIATOR_TIMEOUT_EN` defined: timeout counter and abort path are present as described above.
- Not defined: no counter. BUS waits indefinitely for ack, `resp_err` is tied to 0, and `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `wb_initiator_pkg`:
  - state enum `{IDLE, BUS, RESP}`;
  - default `ADDR_W`/`DATA_W` constants;
  - `SEL_W` derivation.
- Single module, no sub-module. The timeout counter is small enough to stay inline.

## Test plan
- Write `adr=0x3000_0004`, `dat=0xDEAD_BEEF`, `sel=0xF`, slave acks after 2 wait states → bus shows exactly those values with `we=1` for 3 cycles; `resp_val` with `resp_dat=0`, `resp_err=0`.
- Read `adr=0x3000_0010`, slave returns `0x1234_5678` with zero wait → `resp_dat=0x1234_5678` at cycle N+2; with back-to-back commands and `resp_rdy=1`, a new `cyc` every 3 cycles.
- `resp_rdy=0` for 5 cycles after a read → `resp_val` and `resp_dat` stay stable, `cmd_rdy=0` and `cmd_val` is ignored; accepted again the cycle after `resp_rdy`.
- Timeout with `TIMEOUT_CYCLES=8` and the slave never acking → `cyc` high for exactly 8 cycles, then `resp_err=1`, `resp_dat=0`. Ack on the 8th cycle → normal response, `resp_err=0`.
- Reset pulse in the 3rd BUS cycle → `cyc/stb` low next cycle, no `resp_val`, `cmd_rdy=1` one cycle after reset deasserts.
- Macro undefined and ack withheld for 1000 cycles → `cyc` stays high and `resp_err` is never set. A late ack completes normally.
